// File: rtl/qspi_pkg.sv
// Shared state encoding, phase sizes and byte-select helper for the QSPI
// command/address/dummy sequencer.
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    ADDR,
    DUMMY,
    HOLD
  } qspi_seq_state_t;

  localparam int QSPI_CMD_BITS   = 8;
  localparam int QSPI_ADDR_BYTES = 3;

  // Byte index 0 is the opcode slot; 1..3 walk the address MSB first.
  function automatic logic [7:0] qspi_addr_byte(input logic [23:0] addr,
                                                input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd1:    b = addr[23:16];
      2'd2:    b = addr[15:8];
      2'd3:    b = addr[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/qspi_sclk_div.sv
// SCLK half-period timer: counts clk_div+1 cycles and flags the cycle in
// which the sequencer should toggle SCLK.
module qspi_sclk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             edge_tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             hit;

  assign hit         = (cnt_q == div_i);
  assign edge_tick_o = en_i && !clr_i && hit;

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (!en_i || clr_i || hit) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/qspi_xfer_seq.sv
// Single-IO QSPI sequencer for the instruction, address and dummy phases:
// drives cs_n/sclk (mode 0) and the load/shift strobes of the command shifter.
module qspi_xfer_seq
  import qspi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       cmd,
  input  logic [23:0]      addr,
  input  logic             addr_en,
  input  logic [4:0]       dummy_cycles,
  input  logic [DIV_W-1:0] clk_div,
  output logic             busy,
  output logic             done,
  output logic             cs_n,
  output logic             sclk,
  output logic [7:0]       sr_data,
  output logic             sr_load,
  output logic             sr_shift_en
);

  qspi_seq_state_t  state_q;
  logic [23:0]      addr_q;
  logic             addr_en_q;
  logic [4:0]       dummy_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_q;
  logic [1:0]       byte_q;
  logic [4:0]       dmy_q;
  logic             busy_q, done_q, cs_n_q, sclk_q;
  logic [7:0]       sr_data_q;
  logic             sr_load_q, sr_shift_q;

  logic             tick;
  logic             last_byte;
  logic             last_bit;

  qspi_sclk_div #(.DIV_W(DIV_W)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (state_q != IDLE),
    .clr_i       (abort),
    .div_i       (div_q),
    .edge_tick_o (tick)
  );

  assign last_bit  = (bit_q == 3'(QSPI_CMD_BITS - 1));
  assign last_byte = (byte_q == 2'(QSPI_ADDR_BYTES)) || ((byte_q == 2'd0) && !addr_en_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      addr_en_q  <= 1'b0;
      dummy_q    <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      dmy_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      sr_data_q  <= '0;
      sr_load_q  <= 1'b0;
      sr_shift_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      sr_load_q  <= 1'b0;
      sr_shift_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          addr_q    <= addr;
          addr_en_q <= addr_en;
          dummy_q   <= dummy_cycles;
          div_q     <= clk_div;
          bit_q     <= '0;
          byte_q    <= '0;
          dmy_q     <= '0;
          busy_q    <= 1'b1;
          cs_n_q    <= 1'b0;
          sr_data_q <= cmd;
          sr_load_q <= 1'b1;
          state_q   <= SETUP;
        end
      end else if (abort) begin
        busy_q  <= 1'b0;
        cs_n_q  <= 1'b1;
        sclk_q  <= 1'b0;
        state_q <= IDLE;
      end else if (tick) begin
        case (state_q)
          SETUP: begin
            sclk_q  <= 1'b1;
            state_q <= CMD;
          end
          CMD, ADDR: begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // Falling edge: pick the strobe that prepares the next bit.
              sclk_q <= 1'b0;
              bit_q  <= bit_q + 3'd1;
              if (!last_bit) begin
                sr_shift_q <= 1'b1;
              end else if (!last_byte) begin
                sr_load_q <= 1'b1;
                sr_data_q <= qspi_addr_byte(addr_q, byte_q + 2'd1);
                byte_q    <= byte_q + 2'd1;
                state_q   <= ADDR;
              end else if (dummy_q != 5'd0) begin
                sr_shift_q <= 1'b1;
                state_q    <= DUMMY;
              end else begin
                state_q <= HOLD;
              end
            end
          end
          DUMMY: begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (dmy_q == dummy_q - 5'd1) state_q <= HOLD;
              else                         dmy_q   <= dmy_q + 5'd1;
            end
          end
          HOLD: begin
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign cs_n        = cs_n_q;
  assign sclk        = sclk_q;
  assign sr_data     = sr_data_q;
  assign sr_load     = sr_load_q;
  assign sr_shift_en = sr_shift_q;

endmodule

// File: tb/tb_qspi_xfer_seq.sv
// Bench for qspi_xfer_seq: random transactions checked against an edge/strobe
// schedule and MOSI stream derived from the transaction parameters.
module tb_qspi_xfer_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  cmd;
  logic [23:0] addr;
  logic        addr_en;
  logic [4:0]  dummy_cycles;
  logic [7:0]  clk_div;
  logic        busy, done, cs_n, sclk;
  logic [7:0]  sr_data;
  logic        sr_load, sr_shift_en;

  logic [7:0]  sr_m;
  int          errs;
  int          checks;

  qspi_xfer_seq #(.DIV_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cmd          (cmd),
    .addr         (addr),
    .addr_en      (addr_en),
    .dummy_cycles (dummy_cycles),
    .clk_div      (clk_div),
    .busy         (busy),
    .done         (done),
    .cs_n         (cs_n),
    .sclk         (sclk),
    .sr_data      (sr_data),
    .sr_load      (sr_load),
    .sr_shift_en  (sr_shift_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Attached 8-bit command shift register; MOSI is its MSB.
  always @(posedge clk) begin
    if (sr_load)          sr_m <= sr_data;
    else if (sr_shift_en) sr_m <= {sr_m[6:0], 1'b0};
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Runs one full transaction from the current negedge and checks it.
  task automatic run_xact(input logic [7:0] c, input logic [23:0] a, input logic ae,
                          input logic [4:0] dc, input logic [7:0] dv,
                          input bit with_abort, input bit poke_busy);
    int n, hp, nb, budget, cyc, done_cyc, cs_low, busy_hi, shifts;
    int nrise, nfall, edge_err, ldc_err;
    bit both;
    logic prev_sclk;
    logic [63:0] mosi_obs, mosi_exp;
    logic [7:0] exp_b[$];
    logic [7:0] ld_data[$];
    int ld_cyc[$];

    nb  = ae ? 4 : 1;
    n   = 8 * nb + int'(dc);
    hp  = int'(dv) + 1;
    exp_b.push_back(c);
    if (ae) begin
      exp_b.push_back(a[23:16]);
      exp_b.push_back(a[15:8]);
      exp_b.push_back(a[7:0]);
    end
    mosi_exp = '0;
    for (int i = 0; i < nb; i++)
      for (int j = 7; j >= 0; j--) mosi_exp = {mosi_exp[62:0], exp_b[i][j]};
    mosi_exp = mosi_exp << dc;

    budget = 1 + (2 * n + 1) * hp + 10;
    cyc = 1; done_cyc = -1; cs_low = 0; busy_hi = 0; shifts = 0;
    nrise = 0; nfall = 0; edge_err = 0; ldc_err = 0; both = 0;
    prev_sclk = 1'b0; mosi_obs = '0;

    cmd = c; addr = a; addr_en = ae; dummy_cycles = dc; clk_div = dv;
    start = 1'b1; abort = with_abort;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    while (cyc < budget) begin
      if (!cs_n) cs_low++;
      if (busy) busy_hi++;
      if (sclk && !prev_sclk) begin
        nrise++;
        if (cyc != 1 + (2 * nrise - 1) * hp) edge_err++;
        mosi_obs = {mosi_obs[62:0], sr_m[7]};
      end
      if (!sclk && prev_sclk) begin
        nfall++;
        if (cyc != 1 + 2 * nfall * hp) edge_err++;
      end
      prev_sclk = sclk;
      if (sr_load) begin
        ld_data.push_back(sr_data);
        ld_cyc.push_back(cyc);
      end
      if (sr_shift_en) shifts++;
      if (sr_load && sr_shift_en) both = 1;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
      if (poke_busy) begin
        if (cyc == 5) begin
          start = 1'b1; cmd = ~c; addr = ~a; addr_en = ~ae;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;

    check("done_time", 64'(done_cyc), 64'(1 + (2 * n + 1) * hp));
    check("done_state", {cs_n, sclk, busy}, 3'b100);
    check("n_rise", 64'(nrise), 64'(n));
    check("n_fall", 64'(nfall), 64'(n));
    check("edge_timing", 64'(edge_err), 64'd0);
    check("cs_low_len", 64'(cs_low), 64'((2 * n + 1) * hp));
    check("busy_len", 64'(busy_hi), 64'((2 * n + 1) * hp));
    check("n_shift", 64'(shifts), 64'(7 * nb + ((dc != 0) ? 1 : 0)));
    check("load_shift_overlap", 64'(both), 64'd0);
    check("n_load", 64'(ld_data.size()), 64'(nb));
    for (int i = 0; i < nb && i < ld_data.size(); i++) begin
      check("load_byte", 64'(ld_data[i]), 64'(exp_b[i]));
      if (ld_cyc[i] != 1 + 16 * i * hp) ldc_err++;
    end
    check("load_timing", 64'(ldc_err), 64'd0);
    check("mosi", mosi_obs, mosi_exp);
    @(negedge clk);
  endtask

  task automatic run_abort(input logic [4:0] dc, input logic [7:0] dv);
    int rises, cyc;
    logic prev;
    bit seen_done, quiet;
    rises = 0; cyc = 0; prev = 1'b0; seen_done = 0; quiet = 1;
    cmd = 8'h6B; addr = 24'h123456; addr_en = 1'b1; dummy_cycles = dc; clk_div = dv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 2000) begin
      if (sclk && !prev) rises++;
      prev = sclk;
      if (rises >= 5) break;
      @(negedge clk);
      cyc++;
    end
    check("abort_reach_rise5", 64'(rises), 64'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_outputs", {cs_n, sclk, busy, done, sr_load, sr_shift_en}, 6'b100000);
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1;
      if (!cs_n || sclk || busy) quiet = 0;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    check("abort_quiet", 64'(quiet), 64'd1);
  endtask

  task automatic run_reset_mid_addr();
    int loads, cyc;
    loads = 0; cyc = 0;
    cmd = 8'hEB; addr = 24'hC0FFEE; addr_en = 1'b1; dummy_cycles = 5'd4; clk_div = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 2000) begin
      if (sr_load) loads++;
      if (loads >= 2) break;
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_addr", 64'(loads), 64'd2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_addr", {cs_n, sclk, busy, done, sr_load, sr_shift_en, sr_data}, 14'h2000);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    errs = 0; checks = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cmd = '0; addr = '0;
    addr_en = 1'b0; dummy_cycles = '0; clk_div = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {cs_n, sclk, busy, done, sr_load, sr_shift_en, sr_data}, 14'h2000);
    rst_n = 1'b1;
    @(negedge clk);

    run_xact(8'h9F, 24'h000000, 1'b0, 5'd0, 8'd0, 0, 0);
    run_xact(8'h03, 24'hA55AC3, 1'b1, 5'd0, 8'd2, 0, 0);
    run_xact(8'h0B, 24'h8001FE, 1'b1, 5'd8, 8'd1, 0, 0);
    run_abort(5'd3, 8'd1);
    run_xact(8'h05, 24'h000000, 1'b0, 5'd2, 8'd0, 0, 0);
    run_xact(8'h3B, 24'h0F0F0F, 1'b1, 5'd31, 8'd0, 0, 1);
    run_xact(8'hA1, 24'h7E8142, 1'b1, 5'd1, 8'd3, 1, 0);
    run_reset_mid_addr();
    run_xact(8'hC7, 24'h112233, 1'b1, 5'd2, 8'd2, 0, 0);

    for (int i = 0; i < 10; i++)
      run_xact(8'($urandom), 24'($urandom), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), 8'($urandom_range(0, 3)), 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qspi_xfer_seq.md
# qspi_xfer_seq

Single-IO QSPI transfer sequencer that drives the command shift register and the flash pins for the instruction, address and dummy phases of a transaction. Sits between the AHB-side control logic (which supplies opcode, address and timing settings) and the 8-bit command shift register, to which it issues `sr_data`/`sr_load`/`sr_shift_en`. It also generates `sclk` (SPI mode 0) and `cs_n`. The data phase is handled elsewhere and is out of scope.

## Interface
- `DIV_W`, default 8: width of the SCLK half-period divider setting.
- `clk` input 1: system clock (HCLK); all logic on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: request a transaction; sampled only when `busy`=0.
- `abort` input 1: synchronous abort of any in-flight transaction.
- `cmd` input 8: opcode byte, sent MSB first.
- `addr` input 24: address, sent MSB first as 3 bytes.
- `addr_en` input 1: 1 = include the address phase.
- `dummy_cycles` input 5: number of dummy SCLK cycles, 0–31.
- `clk_div` input DIV_W: SCLK half-period = `clk_div`+1 clk cycles.
- `busy` output 1: transaction in progress.
- `done` output 1: 1-cycle pulse on normal completion.
- `cs_n` output 1: flash chip select, active low.
- `sclk` output 1: flash serial clock, registered, idles low.
- `sr_data` output 8: byte to load into the shift register.
- `sr_load` output 1: load strobe to the shift register.
- `sr_shift_en` output 1: shift strobe to the shift register.

## Operation
- States: IDLE, SETUP, CMD, ADDR, DUMMY, HOLD. Defined in the package.
- IDLE + `start` → latch `cmd`, `addr`, `addr_en`, `dummy_cycles`, `clk_div`. Next cycle: `cs_n`=0, `sr_load`=1, `sr_data`=cmd, `busy`=1, go to SETUP.
- Input changes after the latch have no effect until the next start.
- `start` while `busy`=1 is ignored. It is not queued.
- SETUP: `sclk` stays low for one half-period, then rises. Go to CMD.
- Each bit is one SCLK cycle: rising edge (flash samples), high half-period, falling edge, low half-period.
- Strobe issued in the same cycle `sclk` falls:
  - Bit is not the last of its byte → `sr_shift_en`=1.
  - Last bit of a byte, and another byte follows → `sr_load`=1 with the next byte. Order is cmd, then addr[23:16], addr[15:8], addr[7:0].
  - Last bit of a byte, and DUMMY follows → `sr_shift_en`=1, so MOSI=0 during dummy.
  - Final bit of the transaction → no strobe.
- DUMMY: `dummy_cycles` full SCLK cycles with no strobes.
- HOLD: after the final falling edge, `cs_n` stays low for one half-period. Then, in the same cycle: `cs_n`=1, `done`=1, `busy`=0, go to IDLE.
- Total SCLK cycles N = 8 + 24·`addr_en` + `dummy_cycles`.
- `abort` (any state but IDLE): next cycle `cs_n`=1, `sclk`=0, all strobes 0, `busy`=0, no `done`, go to IDLE.
- `abort` and `start` in the same IDLE cycle: `start` is honoured.
- Reset: `cs_n`=1, `sclk`=0, `busy`=0, `done`=0, `sr_load`=0, `sr_shift_en`=0, `sr_data`=0, state IDLE. This applies mid-transaction too.

## Timing
- `start` sampled at cycle T:
  - T+1: `cs_n` falls, `sr_load` pulses.
  - Every SCLK edge k=1..2N occurs at T+1+k·(`clk_div`+1).
  - `done`, `cs_n` rise, and `busy` fall occur at T+1+(2N+1)·(`clk_div`+1).
- `sr_load`/`sr_shift_en` are single-cycle pulses, never asserted together.
- MOSI is valid at least one half-period before each rising edge.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary. Byte index is 0–3. Dummy counter is 5 bits.
- Minimum back-to-back: a new `start` is accepted in the cycle after `done`.

## Structure
- Package `qspi_pkg`:
  - state enum `qspi_seq_state_t`.
  - constants `QSPI_CMD_BITS`=8 and `QSPI_ADDR_BYTES`=3.
- Sub-module `qspi_sclk_div`:
  - half-period counter; reloads from `clk_div` and emits a 1-cycle `edge_tick`.
  - enabled only outside IDLE; cleared by abort/reset.
- Remaining FSM, counters and strobe logic: ~200–300 lines.

## Test plan
- `clk_div`=0, `cmd`=0x9F, `addr_en`=0, dummy=0, start at T:
  - 8 rising `sclk` edges, 7 `sr_shift_en` pulses, 1 `sr_load` (0x9F).
  - `cs_n` low T+1..T+17, `done` at T+18.
  - MOSI via attached shift register = 1,0,0,1,1,1,1,1.
- `clk_div`=2, `cmd`=0x03, `addr`=0xA5_5A_C3, `addr_en`=1, dummy=0:
  - N=32, `sr_load` pulses with 0x03, 0xA5, 0x5A, 0xC3.
  - `done` at T+1+65·3.
- `cmd`=0x0B, `addr_en`=1, `dummy_cycles`=8, `clk_div`=1:
  - N=40; after the last address bit, one `sr_shift_en` then MOSI=0 for 8 SCLK cycles.
  - `done` at T+1+81·2.
- `abort` asserted at the 5th rising `sclk` edge:
  - next cycle `cs_n`=1, `sclk`=0, `busy`=0, no `done`.
  - a fresh `start` is then accepted normally.
- Edge cases:
  - `start` pulsed while `busy` → ignored; no extra `sr_load`.
  - `rst_n`=0 mid-ADDR → all outputs at reset values the next cycle.
  - `start` and `abort` together in IDLE → transaction starts.
